mips_bus_arbiter: RTL
=====================

# mips_bus_arbiter

Two-requester arbiter that shares the CPU's single Avalon-style memory bus (address/read/write/waitrequest/byteenable/readdata/writedata) between the instruction-fetch unit and the load/store unit inside `mips_cpu_bus`. It holds one bus transaction at a time and honours `waitrequest` stalls. It resolves simultaneous requests round-robin and flags over-long stalls with a watchdog.

## Interface
- MAX_WAIT, 255, stall cycles in one transaction before `timeout` sets (≥1)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = in reset)
- i_req  input  1  fetch request, held high until `i_done`
- i_addr  input  32  fetch address, stable while `i_req` high
- i_done  output  1  fetch completes this cycle
- i_rdata  output  32  fetched word, valid only when `i_done`=1
- d_req  input  1  data request, held high until `d_done`
- d_we  input  1  1 = write, 0 = read
- d_addr  input  32  data address
- d_wdata  input  32  write data
- d_be  input  4  byte enables
- d_done  output  1  data access completes this cycle
- d_rdata  output  32  load data, valid only when `d_done`=1 and `d_we`=0
- address  output  32  bus address
- read  output  1  bus read strobe
- write  output  1  bus write strobe
- byteenable  output  4  bus byte enables
- writedata  output  32  bus write data
- waitrequest  input  1  slave stall
- readdata  input  32  bus read data
- timeout  output  1  sticky watchdog flag

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: `read`=`write`=0 and `address`/`byteenable`/`writedata` hold their last values. The state changes on a clock edge:
  - only `i_req` high: go to BUSY_I.
  - only `d_req` high: go to BUSY_D.
  - both high: grant the port not in `last_grant`.
  - neither high: stay in IDLE.
- On grant, register the bus outputs:
  - BUSY_I: `address`=`i_addr`, `read`=1, `write`=0, `byteenable`=4'b1111.
  - BUSY_D: `address`=`d_addr`, `read`=~`d_we`, `write`=`d_we`, `byteenable`=`d_be`, `writedata`=`d_wdata`.
- BUSY_x: hold every bus output stable while `waitrequest`=1.
  - `x_done` = (state==BUSY_x) & ~`waitrequest`, combinational.
  - `i_rdata`/`d_rdata` pass `readdata` through.
  - On the completion edge: return to IDLE and set `last_grant`=x.
- After every completion the arbiter spends exactly one cycle in IDLE. A request still high at the completion edge is therefore never re-granted as stale, and the requester has that edge to drop or replace its request.
- Requester inputs that change while the port is BUSY are ignored; the latched values are used.
- Watchdog:
  - `stall_cnt` ($clog2(MAX_WAIT+1) bits) clears on grant.
  - It increments on each BUSY cycle with `waitrequest`=1 and saturates at MAX_WAIT.
  - `timeout` sets when `stall_cnt` reaches MAX_WAIT and stays set until reset.
  - The transaction is never aborted.

## Timing
- Reset (async, immediate) values: state=IDLE, `last_grant`=D (so the first contended grant goes to fetch), `read`=0, `write`=0, `address`=32'h0, `byteenable`=4'h0, `writedata`=32'h0, `stall_cnt`=0, `timeout`=0. `i_done`/`d_done`=0 because the state is IDLE.
- Reset asserted mid-transaction drops `read`/`write` in the same instant without waiting for a clock. No done pulse is produced. After reset releases, the pending request is re-arbitrated as a fresh request.
- Latency with no stall: request high before edge N, bus strobe high in cycle N..N+1, done in that same cycle, completion at edge N+1, IDLE cycle, next grant at edge N+2. Throughput is one transaction per 2 cycles.
- Each stall cycle adds one cycle before done.
- `i_done` and `d_done` are never high in the same cycle. `read` and `write` are never high in the same cycle.

## Test plan
- Reset then single fetch: `i_req`=1, `i_addr`=32'hBFC00000, `waitrequest`=0 -> next cycle `read`=1, `address`=BFC00000, `byteenable`=F, `i_done`=1, `i_rdata`=`readdata`; the following cycle `read`=0.
- Simultaneous requests after reset: `i_req`=`d_req`=1 (data read of 32'h1000), held -> grants alternate I, D, I, D. Each is separated by one IDLE cycle, and `d_done` appears exactly 2 cycles after `i_done`.
- Stalled write: `d_we`=1, `d_addr`=32'h20, `d_be`=4'b0011, `d_wdata`=32'h12345678, `waitrequest` high for 3 cycles -> `write`, `address`, `byteenable` and `writedata` held stable for 4 cycles. `d_done` is high only in the 4th cycle, and `timeout` stays 0.
- Watchdog: MAX_WAIT=4, `waitrequest` held high for 6 cycles -> `timeout` rises after the 4th stall cycle. The transaction then completes normally, and `timeout` stays 1 until reset.
- Reset mid-operation: assert `reset`=0 during the 2nd stall cycle of a fetch -> `read`=0 immediately with no `i_done`. After release, `i_req` still high -> a fresh grant with `address`=`i_addr`.
- Request changes while busy: during a stalled fetch, change `i_addr` from 32'h100 to 32'h200 -> `address` stays 32'h100 until completion.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory bus between the fetch
// unit and the load/store unit, with a sticky stall watchdog.
module mips_bus_arbiter #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        timeout
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t          state_q;
  logic            last_d_q;
  logic [31:0]     address_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            read_q;
  logic            write_q;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
  logic            timeout_q, timeout_d;
  logic            grant_i, grant_d;

  // On contention, the port that did not win last time gets the bus.
  always_comb begin
    grant_i     = i_req & (~d_req | last_d_q);
    grant_d     = d_req & (~i_req | ~last_d_q);
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    if (state_q == IDLE) begin
      if (grant_i | grant_d) stall_cnt_d = '0;
    end else if (waitrequest) begin
      if (stall_cnt_q != MAX_CNT) stall_cnt_d = stall_cnt_q + CW'(1);
      if (stall_cnt_d == MAX_CNT) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b1;
      address_q   <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q   <= BUSY_I;
            address_q <= i_addr;
            read_q    <= 1'b1;
            write_q   <= 1'b0;
            be_q      <= 4'b1111;
          end else if (grant_d) begin
            state_q   <= BUSY_D;
            address_q <= d_addr;
            read_q    <= ~d_we;
            write_q   <= d_we;
            be_q      <= d_be;
            wdata_q   <= d_wdata;
          end
        end
        BUSY_I, BUSY_D: begin
          // Completion always passes through IDLE so a still-high request is
          // never re-granted on the same edge.
          if (!waitrequest) begin
            state_q  <= IDLE;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            last_d_q <= (state_q == BUSY_D);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_done     = (state_q == BUSY_I) & ~waitrequest;
  assign d_done     = (state_q == BUSY_D) & ~waitrequest;
  assign i_rdata    = readdata;
  assign d_rdata    = readdata;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;
  assign timeout    = timeout_q;

endmodule
